// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity transmitter and its receiving checker.
// Both ends take the parity-sense constants from here so they always agree.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        DATA   = 2'd2,
        PARITY = 2'd3
    } state_t;

    localparam logic PARITY_EVEN  = 1'b0;
    localparam logic PARITY_ODD_C = 1'b1;

endpackage

// File: rtl/parity_tx.sv
// Purpose: serialise a DATA_W word LSB first, then one parity bit (optional start bit: PARITY_TX_START_BIT_EN).
// Latency: first frame bit on tx_bit the cycle after accept; frame is DATA_W+1 cycles (DATA_W+2 with start bit).
// Backpressure: ready_out low while a frame's start/data bits are on the line; a new word may be taken during the parity cycle.
module parity_tx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_last
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic             SENSE    = (PARITY_ODD != 0) ? PARITY_ODD_C : PARITY_EVEN;

    state_t             state;
    logic [DATA_W-1:0]  shreg;
    logic [CNT_W-1:0]   cnt;
    logic               acc;

    assign ready_out = (state == IDLE) || (state == PARITY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            acc      <= 1'b0;
            tx_bit   <= 1'b0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
        end else begin
            case (state)
                IDLE, PARITY: begin
                    tx_last <= 1'b0;
                    if (valid_in) begin
                        tx_valid <= 1'b1;
`ifdef PARITY_TX_START_BIT_EN
                        // The start bit is 0, so leaving it out of acc keeps receiver parity intact.
                        state    <= START;
                        tx_bit   <= 1'b0;
                        shreg    <= data_in;
                        cnt      <= '0;
                        acc      <= 1'b0;
`else
                        state    <= DATA;
                        tx_bit   <= data_in[0];
                        shreg    <= data_in >> 1;
                        cnt      <= CNT_W'(1);
                        acc      <= data_in[0];
`endif
                    end else begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                    end
                end
`ifdef PARITY_TX_START_BIT_EN
                START: begin
                    state  <= DATA;
                    tx_bit <= shreg[0];
                    acc    <= shreg[0];
                    shreg  <= shreg >> 1;
                    cnt    <= CNT_W'(1);
                end
`endif
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        state   <= PARITY;
                        tx_bit  <= acc ^ SENSE;
                        tx_last <= 1'b1;
                    end else begin
                        tx_bit <= shreg[0];
                        acc    <= acc ^ shreg[0];
                        shreg  <= shreg >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_tx.sv
// Bench for parity_tx: an even and an odd instance share inputs; a monitor records every frame bit.
module tb_parity_tx;

    localparam int DW = 8;
`ifdef PARITY_TX_START_BIT_EN
    localparam int SB = 1;
`else
    localparam int SB = 0;
`endif
    localparam int FL = DW + 1 + SB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out, tx_bit, tx_valid, tx_last;
    logic          o_ready, o_bit, o_valid, o_last;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int rdy_err = 0;
    logic qb[$];
    logic ql[$];
    int   qc[$];
    logic ob[$];

    parity_tx #(.DATA_W(DW), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_last(tx_last)
    );

    parity_tx #(.DATA_W(DW), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(o_ready), .tx_bit(o_bit), .tx_valid(o_valid), .tx_last(o_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // While a frame bit is on the line, a word may be taken only during the parity bit.
    always @(negedge clk) begin
        if (tx_valid === 1'b1) begin
            qb.push_back(tx_bit);
            ql.push_back(tx_last);
            qc.push_back(cyc);
            if (ready_out !== tx_last) rdy_err++;
        end
        if (o_valid === 1'b1) ob.push_back(o_bit);
    end

    function automatic logic [15:0] exp_frame(input logic [DW-1:0] w, input bit odd);
        logic [15:0] v = '0;
        for (int i = 0; i < DW; i++) v[SB+i] = w[i];
        v[SB+DW] = (($countones(w) % 2) == 1) ^ odd;
        return v;
    endfunction

    task automatic clear_mon();
        qb.delete(); ql.delete(); qc.delete(); ob.delete();
        rdy_err = 0;
    endtask

    task automatic send(input logic [DW-1:0] w);
        int n = 0;
        data_in  = w;
        valid_in = 1'b1;
        while (ready_out !== 1'b1 && n < 4 * FL) begin
            @(negedge clk);
            n++;
        end
        if (ready_out !== 1'b1) begin
            checks++;
            $display("FAIL accept_timeout: ready_out=%b after %0d cycles, required 1", ready_out, n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        valid_in = 1'b1;
        data_in  = DW'($urandom);
        repeat (2) @(negedge clk);
        checks++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b required 0", tx_valid); else passed++;
        checks++; if (tx_last !== 1'b0) $display("FAIL rst_tx_last: got %b required 0", tx_last); else passed++;
        checks++; if (tx_bit !== 1'b0) $display("FAIL rst_tx_bit: got %b required 0", tx_bit); else passed++;
        rst_n    = 1'b1;
        valid_in = 1'b0;
        checks++; if (ready_out !== 1'b1) $display("FAIL rst_ready: got %b required 1", ready_out); else passed++;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) $display("FAIL post_rst_idle: tx_valid=%b required 0", tx_valid); else passed++;
    endtask

    task automatic test_frame(input logic [DW-1:0] w);
        logic [15:0] ev, ov;
        logic xe, xo;
        clear_mon();
        send(w);
        valid_in = 1'b0;
        repeat (FL + 2) @(negedge clk);
        ev = exp_frame(w, 1'b0);
        ov = exp_frame(w, 1'b1);
        checks++; if (qb.size() != FL) $display("FAIL frame_len %h: got %0d bits required %0d", w, qb.size(), FL); else passed++;
        checks++; if (ob.size() != FL) $display("FAIL odd_frame_len %h: got %0d bits required %0d", w, ob.size(), FL); else passed++;
        xe = 1'b0;
        xo = 1'b0;
        for (int i = 0; i < FL && i < qb.size() && i < ob.size(); i++) begin
            checks++; if (qb[i] !== ev[i]) $display("FAIL bit %h[%0d]: got %b required %b", w, i, qb[i], ev[i]); else passed++;
            checks++; if (ql[i] !== (i == FL - 1)) $display("FAIL last %h[%0d]: got %b required %b", w, i, ql[i], (i == FL - 1)); else passed++;
            checks++; if (qc[i] != qc[0] + i) $display("FAIL gap %h[%0d]: cycle %0d required %0d", w, i, qc[i], qc[0] + i); else passed++;
            checks++; if (ob[i] !== ov[i]) $display("FAIL odd_bit %h[%0d]: got %b required %b", w, i, ob[i], ov[i]); else passed++;
            xe ^= qb[i];
            xo ^= ob[i];
        end
        checks++; if (xe !== 1'b0) $display("FAIL rx_even_parity %h: got %b required 0", w, xe); else passed++;
        checks++; if (xo !== 1'b1) $display("FAIL rx_odd_parity %h: got %b required 1", w, xo); else passed++;
        checks++; if (rdy_err != 0) $display("FAIL ready_during_frame %h: %0d bad cycles required 0", w, rdy_err); else passed++;
    endtask

    task automatic test_known();
        test_frame(8'hA5);
        checks++; if (qb.size() == FL && qb[FL-1] !== 1'b0) $display("FAIL a5_parity: got %b required 0", qb[FL-1]); else passed++;
        test_frame(8'h07);
        checks++; if (qb.size() == FL && qb[FL-1] !== 1'b1) $display("FAIL 07_parity: got %b required 1", qb[FL-1]); else passed++;
        test_frame(8'h00);
        checks++; if (ob.size() == FL && ob[FL-1] !== 1'b1) $display("FAIL 00_odd_parity: got %b required 1", ob[FL-1]); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ev;
        clear_mon();
        send(8'h01);
        send(8'hFF);
        valid_in = 1'b0;
        repeat (FL + 2) @(negedge clk);
        ev = {16'(exp_frame(8'hFF, 1'b0)), 16'(exp_frame(8'h01, 1'b0))};
        checks++; if (qb.size() != 2 * FL) $display("FAIL b2b_len: got %0d bits required %0d", qb.size(), 2 * FL); else passed++;
        for (int i = 0; i < 2 * FL && i < qb.size(); i++) begin
            int k = (i < FL) ? i : 16 + i - FL;
            checks++; if (qb[i] !== ev[k]) $display("FAIL b2b_bit[%0d]: got %b required %b", i, qb[i], ev[k]); else passed++;
            checks++; if (ql[i] !== (i == FL - 1 || i == 2 * FL - 1)) $display("FAIL b2b_last[%0d]: got %b", i, ql[i]); else passed++;
            checks++; if (qc[i] != qc[0] + i) $display("FAIL b2b_gap[%0d]: cycle %0d required %0d", i, qc[i], qc[0] + i); else passed++;
        end
        checks++; if (rdy_err != 0) $display("FAIL b2b_ready: %0d bad cycles required 0", rdy_err); else passed++;
    endtask

    task automatic test_reset_mid();
        int nl = 0;
        clear_mon();
        send(8'h3C);
        valid_in = 1'b0;
        repeat (3 + SB) @(negedge clk);
        checks++; if (tx_bit !== 1'b1 || tx_valid !== 1'b1) $display("FAIL mid_bit3: bit=%b valid=%b required 1,1", tx_bit, tx_valid); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b required 0", tx_valid); else passed++;
        checks++; if (tx_last !== 1'b0) $display("FAIL mid_rst_last: got %b required 0", tx_last); else passed++;
        rst_n = 1'b1;
        checks++; if (ready_out !== 1'b1) $display("FAIL mid_rst_ready: got %b required 1", ready_out); else passed++;
        repeat (FL) @(negedge clk);
        foreach (ql[i]) if (ql[i]) nl++;
        checks++; if (nl != 0) $display("FAIL mid_no_parity: %0d parity bits seen required 0", nl); else passed++;
        checks++; if (qb.size() != 4 + SB) $display("FAIL mid_bits: got %0d bits required %0d", qb.size(), 4 + SB); else passed++;
        test_frame(DW'($urandom));
    endtask

    task automatic test_valid_toggle();
        logic [DW-1:0] w;
        logic [15:0]   ev;
        int            nl = 0;
        w = DW'($urandom);
        clear_mon();
        send(w);
        for (int i = 0; i < FL + 4; i++) begin
            if (ready_out) begin
                valid_in = 1'b0;
            end else begin
                valid_in = 1'($urandom_range(0, 1));
                data_in  = DW'($urandom);
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        ev = exp_frame(w, 1'b0);
        foreach (ql[i]) if (ql[i]) nl++;
        checks++; if (nl != 1) $display("FAIL toggle_frames: %0d frames required 1", nl); else passed++;
        checks++; if (qb.size() != FL) $display("FAIL toggle_len: got %0d bits required %0d", qb.size(), FL); else passed++;
        for (int i = 0; i < FL && i < qb.size(); i++) begin
            checks++; if (qb[i] !== ev[i]) $display("FAIL toggle_bit[%0d]: got %b required %b", i, qb[i], ev[i]); else passed++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) test_frame(DW'($urandom));
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_known();
        test_back_to_back();
        test_reset_mid();
        test_valid_toggle();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
